// File: rtl/pueo_beam_ctrl_pkg.sv
// Shared definitions for the beam threshold control path: sequencer FSM
// state encoding, default threshold width and a beam range helper.
package pueo_beam_ctrl_pkg;

  localparam int THRESH_BITS_DEFAULT = 18;

  // Sequencer state encoding, kept as plain constants for legacy tools
  typedef logic [1:0] bts_state_t;
  localparam bts_state_t ST_IDLE = 2'd0;
  localparam bts_state_t ST_ARM  = 2'd1;
  localparam bts_state_t ST_LOAD = 2'd2;
  localparam bts_state_t ST_DONE = 2'd3;

  // True when an 8-bit beam index addresses a beam that exists
  function automatic logic beam_in_range(input logic [7:0] beam, input int nbeams);
    return (int'(beam) < nbeams);
  endfunction

endpackage

// File: rtl/beam_thresh_shadow.sv
// Shadow threshold register file: one write port, all entries readable in
// parallel so the sequencer can copy any beam into the live set.
module beam_thresh_shadow
  import pueo_beam_ctrl_pkg::*;
#(
  parameter int                     NBEAMS         = 2,
  parameter int                     THRESH_BITS    = THRESH_BITS_DEFAULT,
  parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = '1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_beam_i,
  input  logic [THRESH_BITS-1:0]        wr_data_i,
  output logic [NBEAMS*THRESH_BITS-1:0] rd_all_o
);

  logic [NBEAMS*THRESH_BITS-1:0] shadow_q;

  // Reset every entry to the default, otherwise write the addressed entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= {NBEAMS{THRESH_DEFAULT}};
    end else if (wr_en_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (wr_beam_i == 8'(b)) begin
          shadow_q[b*THRESH_BITS +: THRESH_BITS] <= wr_data_i;
        end
      end
    end
  end

  assign rd_all_o = shadow_q;

endmodule

// File: rtl/beam_threshold_sequencer.sv
// Beam threshold sequencer: host writes go into a shadow file while idle;
// an update request arms the sequencer, and the next trigger frame boundary
// copies the shadow into the live thresholds one beam per cycle.
// Optional feature macro: BEAM_THRESH_READBACK_EN adds a two-cycle live
// threshold readback port.
module beam_threshold_sequencer
  import pueo_beam_ctrl_pkg::*;
#(
  parameter int                     NBEAMS         = 2,
  parameter int                     THRESH_BITS    = THRESH_BITS_DEFAULT,
  parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = 18'h3FFFF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          thresh_wr_i,
  input  logic [7:0]                    thresh_wr_beam_i,
  input  logic [THRESH_BITS-1:0]        thresh_wr_data_i,
  output logic                          thresh_wr_ack_o,
  input  logic                          update_i,
  input  logic                          frame_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NBEAMS*THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]             thresh_ce_o,
  output logic                          err_o
`ifdef BEAM_THRESH_READBACK_EN
  ,
  input  logic                          rd_i,
  input  logic [7:0]                    rd_beam_i,
  output logic [THRESH_BITS-1:0]        rd_data_o,
  output logic                          rd_valid_o
`endif
);

  localparam int IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEAMS - 1);

  bts_state_t                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          pending_q, pending_d;
  logic                          ack_q;
  logic                          err_q;
  logic [NBEAMS-1:0]             ce_q, ce_d;
  logic [NBEAMS*THRESH_BITS-1:0] thr_q, thr_d;
  logic [NBEAMS*THRESH_BITS-1:0] shadow_all;
  logic                          wr_accept;
  logic                          wr_in_range;

  // Writes are only taken while idle; the ack guard keeps a request that is
  // still held during its ack cycle from being taken a second time.
  assign wr_accept   = (state_q == ST_IDLE) && thresh_wr_i && !ack_q;
  assign wr_in_range = beam_in_range(thresh_wr_beam_i, NBEAMS);

  beam_thresh_shadow #(
    .NBEAMS         (NBEAMS),
    .THRESH_BITS    (THRESH_BITS),
    .THRESH_DEFAULT (THRESH_DEFAULT)
  ) u_shadow (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_accept && wr_in_range),
    .wr_beam_i (thresh_wr_beam_i),
    .wr_data_i (thresh_wr_data_i),
    .rd_all_o  (shadow_all)
  );

  // Next-state logic: IDLE -> ARM on update, ARM -> LOAD on frame, LOAD walks
  // the beams, DONE re-arms if an update arrived during the sequence
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (update_i) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (frame_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (update_i) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = (pending_q || update_i) ? ST_ARM : ST_IDLE;
        pending_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Live threshold copy: the beam selected by idx_q loads together with its strobe
  always_comb begin
    ce_d  = '0;
    thr_d = thr_q;
    if (state_q == ST_LOAD) begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (idx_q == IDX_W'(b)) begin
          ce_d[b] = 1'b1;
          thr_d[b*THRESH_BITS +: THRESH_BITS] = shadow_all[b*THRESH_BITS +: THRESH_BITS];
        end
      end
    end
  end

  // Sequencer state, handshake flags and live thresholds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ce_q      <= '0;
      thr_q     <= {NBEAMS{THRESH_DEFAULT}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      ack_q     <= wr_accept;
      err_q     <= err_q | (wr_accept && !wr_in_range);
      ce_q      <= ce_d;
      thr_q     <= thr_d;
    end
  end

  assign thresh_wr_ack_o = ack_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign thresh_o        = thr_q;
  assign thresh_ce_o     = ce_q;
  assign err_o           = err_q;

`ifdef BEAM_THRESH_READBACK_EN
  logic                   rd_vld_p0, rd_vld_p1;
  logic [THRESH_BITS-1:0] rd_data_p0, rd_data_p1;
  logic [THRESH_BITS-1:0] rd_sel;

  // Select the live threshold; beams that do not exist read as zero
  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (rd_beam_i == 8'(b)) rd_sel = thr_q[b*THRESH_BITS +: THRESH_BITS];
    end
  end

  // Stage p0: capture the request; stage p1: present the result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_p0 <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p0 <= rd_i;
      rd_vld_p1 <= rd_vld_p0;
    end
  end

  // Readback data pipeline, qualified by the valid pipeline
  always_ff @(posedge clk_i) begin
    rd_data_p0 <= rd_sel;
    rd_data_p1 <= rd_data_p0;
  end

  assign rd_data_o  = rd_data_p1;
  assign rd_valid_o = rd_vld_p1;
`endif

endmodule

// File: tb/tb_beam_threshold_sequencer.sv
// Scoreboard bench for beam_threshold_sequencer (NBEAMS=2, 18-bit thresholds).
// Optional feature macro: BEAM_THRESH_READBACK_EN exercises the readback port.
module tb_beam_threshold_sequencer;

  localparam int K_ACK  = 0;
  localparam int K_CE   = 1;
  localparam int K_DONE = 2;
  localparam int K_RD   = 3;

  typedef struct {
    int          kind;
    int          beam;
    logic [17:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  wr_beam = 8'd0;
  logic [17:0] wr_data = 18'd0;
  logic        ack;
  logic        upd = 1'b0;
  logic        frame = 1'b0;
  logic        busy;
  logic        done;
  logic [35:0] thr;
  logic [1:0]  ce;
  logic        err;
`ifdef BEAM_THRESH_READBACK_EN
  logic        rd = 1'b0;
  logic [7:0]  rd_beam = 8'd0;
  logic [17:0] rd_data;
  logic        rd_valid;
`endif

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  beam_threshold_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .thresh_wr_i      (wr),
    .thresh_wr_beam_i (wr_beam),
    .thresh_wr_data_i (wr_data),
    .thresh_wr_ack_o  (ack),
    .update_i         (upd),
    .frame_i          (frame),
    .busy_o           (busy),
    .done_o           (done),
    .thresh_o         (thr),
    .thresh_ce_o      (ce),
    .err_o            (err)
`ifdef BEAM_THRESH_READBACK_EN
    ,
    .rd_i             (rd),
    .rd_beam_i        (rd_beam),
    .rd_data_o        (rd_data),
    .rd_valid_o       (rd_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: output seen with nothing expected at %0t", name, $time);
  endtask

  task automatic push(input int kind, input int beam, input logic [17:0] val);
    ev_t e;
    e.kind = kind;
    e.beam = beam;
    e.val  = val;
    q.push_back(e);
  endtask

  function automatic logic [17:0] fld(input logic [35:0] t, input int b);
    return t[b*18 +: 18];
  endfunction

  // Monitor: every presented output is matched against the oldest expectation
  always @(negedge clk) begin
    ev_t e;
    if (ack === 1'b1) begin
      if (q.size() == 0) unexpected("ack");
      else begin
        e = q.pop_front();
        check("ack_kind", K_ACK, e.kind);
      end
    end
    if (ce !== 2'b00 && !$isunknown(ce)) begin
      if (q.size() == 0) unexpected("ce");
      else begin
        e = q.pop_front();
        check("ce_kind", K_CE, e.kind);
        check("ce_mask", ce, 64'(1) << e.beam);
        check("ce_val", fld(thr, e.beam), e.val);
      end
    end
    if (done === 1'b1) begin
      if (q.size() == 0) unexpected("done");
      else begin
        e = q.pop_front();
        check("done_kind", K_DONE, e.kind);
      end
    end
`ifdef BEAM_THRESH_READBACK_EN
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) unexpected("rd");
      else begin
        e = q.pop_front();
        check("rd_kind", K_RD, e.kind);
        check("rd_val", rd_data, e.val);
      end
    end
`endif
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    bit got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (ack === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: no ack within %0d cycles", n);
    end
  endtask

  task automatic do_write(input logic [7:0] b, input logic [17:0] d);
    push(K_ACK, 0, 18'd0);
    wr_beam = b;
    wr_data = d;
    wr = 1'b1;
    wait_ack();
    wr = 1'b0;
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic push_load(input logic [17:0] v0, input logic [17:0] v1);
    push(K_CE, 0, v0);
    push(K_CE, 1, v1);
    push(K_DONE, 0, 18'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_thr", thr, {2{18'h3FFFF}});
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ack", ack, 0);
    check("rst_ce", ce, 0);
    rst = 1'b0;
    tick();

    // Basic load: beam1 = 0x1000, frame five cycles after update
    do_write(8'd1, 18'h01000);
    pulse_update();
    tick(4);
    check("arm_busy", busy, 1);
    push_load(18'h3FFFF, 18'h01000);
    pulse_frame();
    tick(4);
    check("t1_beam1", fld(thr, 1), 18'h01000);
    check("t1_busy", busy, 0);
    check("t1_queue", q.size(), 0);

    // Write during ARM is held off until after DONE
    push_load(18'h3FFFF, 18'h01000);
    push(K_ACK, 0, 18'd0);
    pulse_update();
    wr_beam = 8'd0;
    wr_data = 18'h00ABC;
    wr = 1'b1;
    tick(3);
    check("arm_noack", ack, 0);
    check("arm_busy2", busy, 1);
    pulse_frame();
    wait_ack();
    wr = 1'b0;
    tick(2);
    push_load(18'h00ABC, 18'h01000);
    pulse_update();
    tick(2);
    pulse_frame();
    tick(4);
    check("t2_thr", thr, {18'h01000, 18'h00ABC});

    // Out-of-range beam write: acked, flagged, discarded
    do_write(8'd7, 18'h00055);
    check("t3_err", err, 1);
    check("t3_thr", thr, {18'h01000, 18'h00ABC});
    push_load(18'h00ABC, 18'h01000);
    pulse_update();
    tick(2);
    pulse_frame();
    tick(4);
    check("t3_thr_after_load", thr, {18'h01000, 18'h00ABC});
    check("t3_err_sticky", err, 1);

    // Update during LOAD re-arms after DONE and waits for a new frame
    push_load(18'h00ABC, 18'h01000);
    push_load(18'h00ABC, 18'h01000);
    pulse_update();
    tick(2);
    pulse_frame();
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick(5);
    check("t4_rearm_busy", busy, 1);
    check("t4_queue_mid", q.size(), 3);
    pulse_frame();
    tick(4);
    check("t4_busy", busy, 0);
    check("t4_queue", q.size(), 0);

    // Reset while beam1 is being loaded
    do_write(8'd0, 18'h00111);
    do_write(8'd1, 18'h00222);
    push(K_CE, 0, 18'h00111);
    pulse_update();
    tick(2);
    pulse_frame();
    tick();
    rst = 1'b1;
    tick();
    check("t5_thr", thr, {2{18'h3FFFF}});
    check("t5_busy", busy, 0);
    check("t5_err", err, 0);
    check("t5_ce", ce, 0);
    rst = 1'b0;
    tick(3);
    check("t5_idle", busy, 0);
    check("t5_queue", q.size(), 0);

`ifdef BEAM_THRESH_READBACK_EN
    // Readback of a freshly loaded threshold, plus an out-of-range read
    do_write(8'd0, 18'h00ABC);
    push_load(18'h00ABC, 18'h3FFFF);
    pulse_update();
    tick(2);
    pulse_frame();
    tick(4);
    push(K_RD, 0, 18'h00ABC);
    rd_beam = 8'd0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_not_yet", rd_valid, 0);
    tick();
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, 18'h00ABC);
    tick(2);
    push(K_RD, 0, 18'h00000);
    rd_beam = 8'd5;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick(3);
`endif

    tick(3);
    check("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beam_threshold_sequencer.md
BEAM_THRESHOLD_SEQUENCER -- requirements
Module: beam_threshold_sequencer

Interface
REQ-001 SHALL have parameter NBEAMS, default 2: number of beams served.
REQ-002 SHALL have parameter THRESH_BITS, default 18: threshold width per beam.
REQ-003 SHALL have parameter THRESH_DEFAULT, default 18'h3FFFF: reset threshold for every beam.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port thresh_wr_i, input, 1: shadow-write request.
REQ-007 SHALL have port thresh_wr_beam_i, input, 8: beam index of write.
REQ-008 SHALL have port thresh_wr_data_i, input, THRESH_BITS: threshold value.
REQ-009 SHALL have port thresh_wr_ack_o, output, 1: one-cycle write acknowledge.
REQ-010 SHALL have port update_i, input, 1: request to apply shadow thresholds.
REQ-011 SHALL have port frame_i, input, 1: trigger-datapath frame-boundary strobe.
REQ-012 SHALL have port busy_o, output, 1: update armed or in progress.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse at update completion.
REQ-014 SHALL have port thresh_o, output, NBEAMS*THRESH_BITS: live thresholds; beam b at bits [b*THRESH_BITS +: THRESH_BITS].
REQ-015 SHALL have port thresh_ce_o, output, NBEAMS: per-beam load strobe, asserted in the cycle thresh_o for that beam changes.
REQ-016 SHALL have port err_o, output, 1: sticky out-of-range write flag.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, LOAD, DONE.
REQ-018 SHALL, in IDLE with thresh_wr_i high, write shadow[beam] and assert thresh_wr_ack_o the next cycle.
REQ-019 SHALL withhold thresh_wr_ack_o and leave the shadow unchanged while in ARM, LOAD or DONE; the requester holds thresh_wr_i until acked.
REQ-020 SHALL, for thresh_wr_beam_i >= NBEAMS, ack normally, discard the data, and set err_o until reset.
REQ-021 SHALL go IDLE->ARM the cycle after update_i high; update_i and thresh_wr_i together in IDLE: write taken first, ARM still entered.
REQ-022 SHALL remain in ARM until frame_i is sampled high, then enter LOAD next cycle.
REQ-023 SHALL, in LOAD, update one beam per cycle in index order 0..NBEAMS-1, asserting only that beam's thresh_ce_o bit; LOAD lasts exactly NBEAMS cycles.
REQ-024 SHALL enter DONE for one cycle with done_o high, then return to IDLE.
REQ-025 SHALL assert busy_o exactly in ARM, LOAD and DONE.
REQ-026 SHALL ignore update_i in ARM; in LOAD or DONE set a pending flag that sends DONE->ARM instead of IDLE.
REQ-027 SHALL ignore frame_i outside ARM; frame_i in the same cycle ARM is entered is not used.
REQ-028 SHALL hold thresh_o stable except for the beam strobed by thresh_ce_o.

Reset
REQ-029 SHALL, on rst_i, set FSM to IDLE, every shadow entry and thresh_o field to THRESH_DEFAULT, thresh_ce_o/ack/done/busy/err/pending to 0.
REQ-030 SHALL, on rst_i mid-LOAD, abandon the sequence; thresholds already loaded are overwritten by THRESH_DEFAULT.

Configuration
REQ-031 SHALL, with BEAM_THRESH_READBACK_EN defined, add inputs rd_i (1), rd_beam_i (8) and outputs rd_data_o (THRESH_BITS), rd_valid_o (1): live threshold returned with rd_valid_o two cycles after rd_i; out-of-range reads return 0.
REQ-032 SHALL, without BEAM_THRESH_READBACK_EN, omit those ports and logic entirely.

Structure
REQ-033 SHALL place the FSM state typedef and THRESH_BITS default in shared package pueo_beam_ctrl_pkg.
REQ-034 SHALL implement the shadow register file as sub-module beam_thresh_shadow (write port, NBEAMS-wide parallel read).

Verification
REQ-035 SHALL test: write beam1=0x1000, update_i, frame_i 5 cycles later -> ce 01 then 10, thresh_o beam1=0x1000, done_o once.
REQ-036 SHALL test: write during ARM -> no ack until after DONE, then acked and shadow updated.
REQ-037 SHALL test: write beam 7 with NBEAMS=2 -> ack, err_o=1, thresholds unchanged.
REQ-038 SHALL test: update_i during LOAD -> second ARM after DONE, second load on next frame_i.
REQ-039 SHALL test: rst_i during LOAD beam1 -> all thresh_o=0x3FFFF, IDLE, busy_o=0.
REQ-040 SHALL test: with BEAM_THRESH_READBACK_EN, rd beam0 after load of 0x0ABC -> rd_data_o=0x0ABC two cycles later.
